// File: rtl/noc_params.sv
// Shared NoC definitions: flit format and address/payload field widths.
package noc_params;

    localparam int unsigned VC_SIZE           = 2;
    localparam int unsigned DEST_ADDR_SIZE_X  = 4;
    localparam int unsigned DEST_ADDR_SIZE_Y  = 4;
    localparam int unsigned HEAD_PAYLOAD_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    typedef struct packed {
        flit_label_t                   flit_label;
        logic [VC_SIZE-1:0]            vc_id;
        logic [DEST_ADDR_SIZE_X-1:0]   x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]   y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0]  head_pl;
    } flit_t;

endpackage

// File: rtl/circular_buffer.sv
// First-word fall-through flit FIFO with on/off upstream flow control that
// reserves room for the flits still in flight when on_off_o drops.
module circular_buffer
    import noc_params::*;
#(
    parameter int unsigned BUFFER_SIZE    = 8,
    parameter int unsigned PIPELINE_DEPTH = 5
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  write_i,
    input  logic  read_i,
    output flit_t data_o,
    output logic  is_full_o,
    output logic  is_empty_o,
    output logic  on_off_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    flit_t            memory [BUFFER_SIZE];
    logic [PTR_W-1:0] read_ptr;
    logic [PTR_W-1:0] write_ptr;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_slots;
    logic             do_read;
    logic             do_write;

    always_comb begin
        is_full_o  = (occupancy == CNT_W'(BUFFER_SIZE));
        is_empty_o = (occupancy == '0);
        free_slots = CNT_W'(BUFFER_SIZE) - occupancy;
        on_off_o   = (free_slots > CNT_W'(PIPELINE_DEPTH));
        data_o     = memory[read_ptr];
    end

    // A write while full is legal only when a read frees the head slot in the
    // same cycle; a read while empty is dropped, so no data_i bypass occurs.
    always_comb begin
        do_read  = read_i && !is_empty_o;
        do_write = write_i && (!is_full_o || read_i);
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            memory[write_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            occupancy <= '0;
        end else begin
            if (do_write) begin
                write_ptr <= write_ptr + PTR_W'(1);
            end
            if (do_read) begin
                read_ptr <= read_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_circular_buffer.sv
// Directed bench for circular_buffer: ordering, full/empty limits,
// simultaneous read/write, on/off thresholds, wrap and asynchronous reset.
module tb_circular_buffer;
    import noc_params::*;

    logic  clk;
    logic  rst;
    flit_t data_i;
    logic  write_i;
    logic  read_i;
    flit_t data_o;
    logic  is_full_o;
    logic  is_empty_o;
    logic  on_off_o;

    int unsigned checks;
    int unsigned errors;

    circular_buffer #(
        .BUFFER_SIZE   (8),
        .PIPELINE_DEPTH(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .write_i   (write_i),
        .read_i    (read_i),
        .data_o    (data_o),
        .is_full_o (is_full_o),
        .is_empty_o(is_empty_o),
        .on_off_o  (on_off_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic flit_t mk(input int unsigned n);
        flit_t f;
        f.flit_label = flit_label_t'(n % 4);
        f.vc_id      = VC_SIZE'(n / 4);
        f.x_dest     = DEST_ADDR_SIZE_X'(n + 3);
        f.y_dest     = DEST_ADDR_SIZE_Y'(n * 5);
        f.head_pl    = HEAD_PAYLOAD_SIZE'(16'hA000 + n * 37);
        return f;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_i = 1'b0;
        read_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        data_i = '0;
        #13;
        checks++; if (is_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", is_empty_o); end
        checks++; if (is_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", is_full_o); end
        checks++; if (on_off_o !== 1'b1) begin errors++; $display("FAIL reset_on_off got %b exp 1", on_off_o); end
        checks++; if (dut.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", dut.occupancy); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_fifo_order();
        flit_t a, b, c;
        a = mk(1); b = mk(2); c = mk(3);
        write_i = 1'b1; data_i = a;
        tick();
        checks++; if (is_empty_o !== 1'b0) begin errors++; $display("FAIL order_not_empty got %b exp 0", is_empty_o); end
        checks++; if (data_o !== a) begin errors++; $display("FAIL order_head_a got %h exp %h", data_o, a); end
        data_i = b; tick();
        data_i = c; tick();
        idle(); read_i = 1'b1;
        tick();
        checks++; if (data_o !== b) begin errors++; $display("FAIL order_head_b got %h exp %h", data_o, b); end
        tick();
        checks++; if (data_o !== c) begin errors++; $display("FAIL order_head_c got %h exp %h", data_o, c); end
        checks++; if (is_empty_o !== 1'b0) begin errors++; $display("FAIL order_one_left got %b exp 0", is_empty_o); end
        tick();
        checks++; if (is_empty_o !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", is_empty_o); end
        idle();
    endtask

    task automatic test_full();
        flit_t x;
        x = mk(99);
        write_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_i = mk(10 + i);
            tick();
        end
        checks++; if (is_full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", is_full_o); end
        checks++; if (on_off_o !== 1'b0) begin errors++; $display("FAIL full_on_off got %b exp 0", on_off_o); end
        data_i = x;
        tick();
        checks++; if (dut.occupancy !== 4'd8) begin errors++; $display("FAIL full_ignore_occ got %0d exp 8", dut.occupancy); end
        idle(); read_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (data_o !== mk(10 + i)) begin
                errors++; $display("FAIL full_drain_%0d got %h exp %h", i, data_o, mk(10 + i));
            end
            tick();
        end
        checks++; if (is_empty_o !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", is_empty_o); end
        idle();
    endtask

    task automatic test_back_to_back();
        flit_t f1, f2, d;
        f1 = mk(20); f2 = mk(21); d = mk(22);
        write_i = 1'b1;
        data_i = f1; tick();
        data_i = f2; tick();
        read_i = 1'b1; data_i = d;
        tick();
        checks++; if (dut.occupancy !== 4'd2) begin errors++; $display("FAIL rw_occ got %0d exp 2", dut.occupancy); end
        checks++; if (data_o !== f2) begin errors++; $display("FAIL rw_head got %h exp %h", data_o, f2); end
        write_i = 1'b0;
        tick();
        checks++; if (data_o !== d) begin errors++; $display("FAIL rw_last got %h exp %h", data_o, d); end
        tick();
        checks++; if (is_empty_o !== 1'b1) begin errors++; $display("FAIL rw_empty got %b exp 1", is_empty_o); end
        idle();
    endtask

    task automatic test_rw_empty();
        flit_t e;
        e = mk(30);
        write_i = 1'b1; read_i = 1'b1; data_i = e;
        tick();
        idle();
        checks++; if (is_empty_o !== 1'b0) begin errors++; $display("FAIL rwe_not_empty got %b exp 0", is_empty_o); end
        checks++; if (data_o !== e) begin errors++; $display("FAIL rwe_head got %h exp %h", data_o, e); end
        checks++; if (dut.occupancy !== 4'd1) begin errors++; $display("FAIL rwe_occ got %0d exp 1", dut.occupancy); end
        read_i = 1'b1; tick(); idle();
    endtask

    task automatic test_on_off();
        write_i = 1'b1;
        data_i = mk(40); tick();
        data_i = mk(41); tick();
        checks++; if (on_off_o !== 1'b1) begin errors++; $display("FAIL onoff_at2 got %b exp 1", on_off_o); end
        data_i = mk(42); tick();
        checks++; if (on_off_o !== 1'b0) begin errors++; $display("FAIL onoff_at3 got %b exp 0", on_off_o); end
        idle(); read_i = 1'b1;
        tick();
        checks++; if (on_off_o !== 1'b1) begin errors++; $display("FAIL onoff_read got %b exp 1", on_off_o); end
        tick(); tick(); idle();
    endtask

    task automatic test_random_and_reset();
        flit_t q[$];
        flit_t z;
        logic  wr, rd;
        int unsigned tag;
        tag = 100;
        for (int i = 0; i < 20; i++) begin
            wr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 1) != 0);
            write_i = wr; read_i = rd; data_i = mk(tag);
            tick();
            if (rd && q.size() > 0) void'(q.pop_front());
            if (wr && (q.size() < 8 || rd)) begin
                q.push_back(mk(tag));
                tag++;
            end
            checks++;
            if (is_empty_o !== (q.size() == 0) || is_full_o !== (q.size() == 8)) begin
                errors++; $display("FAIL rand_flags_%0d got e%b f%b exp size %0d", i, is_empty_o, is_full_o, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (data_o !== q[0]) begin
                    errors++; $display("FAIL rand_head_%0d got %h exp %h", i, data_o, q[0]);
                end
            end
        end
        idle();
        while (q.size() > 4) begin
            read_i = 1'b1; tick(); void'(q.pop_front());
        end
        read_i = 1'b0;
        while (q.size() < 4) begin
            write_i = 1'b1; data_i = mk(tag); tick(); q.push_back(mk(tag)); tag++;
        end
        idle();
        checks++; if (dut.occupancy !== 4'd4) begin errors++; $display("FAIL pre_reset_occ got %0d exp 4", dut.occupancy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (is_empty_o !== 1'b1) begin errors++; $display("FAIL async_empty got %b exp 1", is_empty_o); end
        checks++; if (on_off_o !== 1'b1) begin errors++; $display("FAIL async_on_off got %b exp 1", on_off_o); end
        checks++; if (dut.occupancy !== 4'd0) begin errors++; $display("FAIL async_occ got %0d exp 0", dut.occupancy); end
        tick();
        z = mk(77);
        rst = 1'b1; write_i = 1'b1; data_i = z;
        tick();
        idle();
        checks++; if (is_empty_o !== 1'b0) begin errors++; $display("FAIL post_reset_write got %b exp 0", is_empty_o); end
        checks++; if (data_o !== z) begin errors++; $display("FAIL post_reset_head got %h exp %h", data_o, z); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fifo_order();
        test_full();
        test_back_to_back();
        test_rw_empty();
        test_on_off();
        test_random_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/circular_buffer.md
CIRCULAR_BUFFER -- requirements
Module: circular_buffer

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 8, number of flit slots; power of two, >= 2.
REQ-002 SHALL have parameter PIPELINE_DEPTH, default 5, upstream round-trip flits in flight after on_off_o drops; 1 <= PIPELINE_DEPTH < BUFFER_SIZE.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have data_i  input  flit_t  flit to enqueue.
REQ-006 SHALL have write_i  input  1  enqueue data_i at the next rising edge.
REQ-007 SHALL have read_i  input  1  dequeue the head flit at the next rising edge.
REQ-008 SHALL have data_o  output  flit_t  current head flit, first-word fall-through.
REQ-009 SHALL have is_full_o  output  1  high when occupancy == BUFFER_SIZE.
REQ-010 SHALL have is_empty_o  output  1  high when occupancy == 0.
REQ-011 SHALL have on_off_o  output  1  upstream flow control; 1 = may send, 0 = stop.

Function
REQ-012 SHALL store flits in FIFO order: BUFFER_SIZE-entry memory, read pointer, write pointer, occupancy counter of width $clog2(BUFFER_SIZE)+1.
REQ-013 SHALL drive data_o combinationally from memory[read pointer]; head available the cycle after its write edge; data_o is don't-care while is_empty_o = 1.
REQ-014 Write only, not full: store data_i at write pointer; write pointer +1 mod BUFFER_SIZE; occupancy +1.
REQ-015 Read only, not empty: read pointer +1 mod BUFFER_SIZE; occupancy -1; data_o shows the next flit after the edge.
REQ-016 Read and write, not empty: both performed in the same cycle; occupancy unchanged; legal when full.
REQ-017 Read and write, empty: only the write is performed; no bypass from data_i to data_o; occupancy becomes 1.
REQ-018 Write while full without read SHALL be ignored; no pointer, count or memory change.
REQ-019 Read while empty SHALL be ignored.
REQ-020 Pointers SHALL wrap from BUFFER_SIZE-1 to 0 with no bubble.
REQ-021 is_full_o and is_empty_o SHALL be combinational decodes of the occupancy register; no extra latency.
REQ-022 on_off_o SHALL be combinational: 1 when (BUFFER_SIZE - occupancy) > PIPELINE_DEPTH, else 0; defaults give on for occupancy 0..2 and off for 3..8.

Reset
REQ-023 While rst = 0, regardless of clk: pointers = 0, occupancy = 0, is_empty_o = 1, is_full_o = 0, on_off_o = 1.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 Reset asserted mid-operation SHALL discard all stored flits immediately.
REQ-026 The first write SHALL be accepted on the first rising edge after rst returns to 1.

Structure
REQ-027 flit_t, its flit_label_t enum (HEAD, BODY, TAIL, HEADTAIL), VC_SIZE, DEST_ADDR_SIZE_X, DEST_ADDR_SIZE_Y and HEAD_PAYLOAD_SIZE SHALL come from shared package noc_params; nothing redefined locally.
REQ-028 circular_buffer SHALL be a single module with no sub-modules; memory SHALL be a named unpacked array memory[BUFFER_SIZE] so benches can probe it.

Verification
REQ-029 Reset, then 3 writes of flits A, B, C; 3 reads -> data_o = A, B, C in order; is_empty_o = 1 after the third read; is_empty_o = 0 after the first write edge.
REQ-030 8 writes -> is_full_o = 1; 9th write of X ignored; 8 reads return the first 8 flits and never X.
REQ-031 2 writes, then read+write of D -> occupancy stays 2, data_o advances to the second flit, D returned last.
REQ-032 Empty buffer, read+write of E -> is_empty_o = 0 next cycle, data_o = E, occupancy = 1.
REQ-033 Fill to 2 -> on_off_o = 1; 3rd write -> on_off_o = 0; one read -> on_off_o = 1.
REQ-034 Pointer wrap and mid-stream reset: 20 random mixed operations checked against a reference queue with no mismatches; then reset with 4 flits stored -> is_empty_o = 1, on_off_o = 1 at once.
